uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, number of rx_tick pulses per bit period; it shall be an even value of 4 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-005 SHALL have port rx_tick, input, 1 bit: a one-clk enable pulse at baud rate times OVERSAMPLE.
REQ-006 SHALL have port rx_serial, input, 1 bit: the asynchronous serial line, which idles high.
REQ-007 SHALL have port rx_data, output, DATA_BITS wide: the last good received byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: a one-clk pulse when rx_data updates.
REQ-009 SHALL have port frame_error, output, 1 bit: a one-clk pulse when a frame has a bad stop bit.
REQ-010 SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL pass rx_serial through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value rxs.
REQ-012 SHALL use the states IDLE, START, DATA, STOP and BREAK.
REQ-013 SHALL act only on clk edges where rx_tick=1; on all other edges the counters and state hold.
REQ-014 IDLE: on a tick with rxs=0, SHALL clear the tick counter and go to START.
REQ-015 START: when the tick counter reaches OVERSAMPLE/2-1 (mid start bit), SHALL go to DATA with counters cleared if rxs=0; if rxs=1 it is a false start and SHALL go to IDLE with no outputs.
REQ-016 DATA: every OVERSAMPLE ticks, SHALL sample rxs into the shift register, LSB first; after DATA_BITS samples it SHALL go to STOP.
REQ-017 STOP: after OVERSAMPLE ticks, if rxs=1 SHALL load rx_data, pulse rx_valid and go to IDLE.
REQ-018 STOP: after OVERSAMPLE ticks, if rxs=0 SHALL pulse frame_error, leave rx_data unchanged and go to BREAK.
REQ-019 BREAK: SHALL wait for rxs=1 on a tick, then go to IDLE, so that a held-low line produces exactly one frame_error.
REQ-020 rx_valid and frame_error SHALL be registered and assert in the clk cycle after the stop-sample tick edge; they are never high together.
REQ-021 rx_data SHALL hold its value until the next good frame; there is no consumer backpressure and a missed pulse is lost.
REQ-022 A new start bit SHALL be accepted on the first tick in IDLE after a good stop, with no extra idle ticks required.
REQ-023 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide and the bit counter $clog2(DATA_BITS+1) bits wide; both wrap to 0 explicitly and never overflow.

Reset
REQ-024 On reset=1 at a clk edge, the state SHALL become IDLE, both counters and the shift register 0, rx_data 0, rx_valid/frame_error/rx_busy 0, and the synchronizer flops 1.
REQ-025 Reset mid-frame SHALL discard the partial frame with no rx_valid or frame_error, and reset SHALL take priority over rx_tick.

Structure
REQ-026 The state enumeration and the default OVERSAMPLE/DATA_BITS constants SHALL live in the shared package uart_pkg, which the transmitter also uses.
REQ-027 The synchronizer SHALL be a separate sub-module sync_2ff (1 bit, reset value parameterized); all other logic SHALL be in a single FSM always block plus the output registers.

Verification
REQ-028 Bench SHALL send frame 0xA5 at 16 ticks/bit with 8-cycle tick spacing -> one rx_valid with rx_data=0xA5 and frame_error=0.
REQ-029 Bench SHALL drive a 3-tick low glitch on an idle line -> no rx_valid, no frame_error, and rx_busy returning to 0 by tick 8.
REQ-030 Bench SHALL send 0x3C with the stop bit low, then hold the line low for 40 ticks -> exactly one frame_error, rx_data unchanged, and the state in BREAK until the line goes high.
REQ-031 Bench SHALL send 0x00 and 0xFF back-to-back with zero idle -> two rx_valid pulses 160 ticks apart, carrying 0x00 then 0xFF.
REQ-032 Bench SHALL assert reset during data bit 4 of 0x81, release it, then send 0x42 -> no output for the aborted frame, then rx_valid with 0x42.
REQ-033 Bench SHALL add a timing-skew check: baud off by ±3% over 0x55 -> rx_data=0x55 correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial-in / byte-out signal bundle of the UART receiver.
interface uart_receiver_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS
);
    logic                 rx_tick;
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_error;
    logic                 rx_busy;

    modport master (
        output rx_tick, rx_serial,
        input  rx_data, rx_valid, frame_error, rx_busy
    );

    modport slave (
        input  rx_tick, rx_serial,
        output rx_data, rx_valid, frame_error, rx_busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: mid-bit sampling, LSB first, one stop bit, break detection.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rxs;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx_serial),
        .q     (rxs)
    );

    uart_state_e          state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt, fe_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.frame_error <= 1'b0;
        end else begin
            state           <= state_nxt;
            tick_cnt        <= tick_nxt;
            bit_cnt         <= bit_nxt;
            shift           <= shift_nxt;
            bus.rx_data     <= data_nxt;
            bus.rx_valid    <= valid_nxt;
            bus.frame_error <= fe_nxt;
        end
    end

    // Everything holds between ticks; pulses clear on every clk.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        data_nxt  = bus.rx_data;
        valid_nxt = 1'b0;
        fe_nxt    = 1'b0;
        if (bus.rx_tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        tick_nxt  = '0;
                        state_nxt = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt  = '0;
                        shift_nxt = {rxs, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_nxt   = '0;
                            state_nxt = ST_STOP;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt = '0;
                        if (rxs) begin
                            data_nxt  = shift;
                            valid_nxt = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            fe_nxt    = 1'b1;
                            state_nxt = ST_BREAK;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxs) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.rx_busy = (state != ST_IDLE);
endmodule
